// File: rtl/sram_sample_unpacker_if.sv
// Unpacked sample stream toward the forward DCT: valid/ready handshake carrying 16-bit signed samples.
interface sram_sample_unpacker_if;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sample;

  modport master (output out_valid, output out_sample, input out_ready);
  modport slave  (input out_valid, input out_sample, output out_ready);
endinterface

// File: rtl/sram_sample_unpacker.sv
// Reads packed byte pairs from SRAM and emits level-shifted signed samples, high byte first; first sample 4 cycles after start.
// Backpressure: out_ready stalls the stream; reads are throttled so in-flight plus buffered words never exceed BUF_DEPTH.
module sram_sample_unpacker #(
  parameter int ADDR_W      = 18,
  parameter int LEVEL_SHIFT = 128,
  parameter int BUF_DEPTH   = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [15:0]            word_count,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      SRAM_address,
  output logic                   SRAM_we_n,
  input  logic [15:0]            SRAM_read_data,
  sram_sample_unpacker_if.master smp
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;
  state_t state;

  logic [ADDR_W-1:0] next_addr;
  logic [15:0]       issue_left;
  logic              issued;   // SRAM_address holds a live read this cycle
  logic [1:0]        rd_pipe;

  logic [15:0]       buf_mem [BUF_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     buf_cnt;
  logic              lo_half;

  logic [CW-1:0]     inflight;
  logic [CW:0]       occupancy;
  logic              can_issue;
  logic              buf_wr;
  logic              buf_pop;
  logic              xfer;
  logic              drained;
  logic [7:0]        head_byte;

  assign SRAM_we_n = 1'b1;

  assign inflight  = CW'(issued) + CW'(rd_pipe[0]) + CW'(rd_pipe[1]);
  assign occupancy = (CW+1)'(inflight) + (CW+1)'(buf_cnt);
  assign can_issue = occupancy < (CW+1)'(BUF_DEPTH);

  assign buf_wr  = rd_pipe[1];
  assign xfer    = smp.out_valid && smp.out_ready;
  assign buf_pop = xfer && lo_half;

  // Finish as soon as the last sample leaves, not a cycle later.
  assign drained = (inflight == '0) &&
                   ((buf_cnt == '0) || ((buf_cnt == CW'(1)) && buf_pop));

  assign head_byte      = lo_half ? buf_mem[rd_ptr][7:0] : buf_mem[rd_ptr][15:8];
  assign smp.out_valid  = (buf_cnt != '0);
  assign smp.out_sample = smp.out_valid ? ({8'h00, head_byte} - 16'(LEVEL_SHIFT)) : 16'h0000;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      SRAM_address <= '0;
      next_addr    <= '0;
      issue_left   <= '0;
      issued       <= 1'b0;
      rd_pipe      <= '0;
    end else begin
      issued  <= 1'b0;
      rd_pipe <= {rd_pipe[0], issued};
      case (state)
        IDLE: begin
          if (start) begin
            next_addr  <= base_addr;
            issue_left <= word_count;
            busy       <= 1'b1;
            state      <= (word_count == 16'd0) ? FINISH : ISSUE;
          end
        end
        ISSUE: begin
          if (can_issue) begin
            SRAM_address <= next_addr;
            next_addr    <= next_addr + ADDR_W'(1);
            issue_left   <= issue_left - 16'd1;
            issued       <= 1'b1;
            if (issue_left == 16'd1) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drained) begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FINISH: begin
          // A zero-length transfer arrives here with done low and spends one busy cycle first.
          if (done) begin
            done  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      buf_cnt <= '0;
      lo_half <= 1'b0;
    end else begin
      if (buf_wr) begin
        buf_mem[wr_ptr] <= SRAM_read_data;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (xfer)    lo_half <= ~lo_half;
      if (buf_pop) rd_ptr  <= rd_ptr + PW'(1);
      buf_cnt <= buf_cnt + CW'(buf_wr) - CW'(buf_pop);
    end
  end

  buf_no_overflow: assert property (@(posedge Clock) disable iff (Reset)
    !(buf_wr && !buf_pop && (buf_cnt == CW'(BUF_DEPTH))));

endmodule

// File: tb/tb_sram_sample_unpacker.sv
// Directed bench for sram_sample_unpacker: table-driven transfers plus backpressure, zero-length, restart and reset sequences.
module tb_sram_sample_unpacker;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [15:0]   word_count = '0;
  logic          rdy = 1'b1;
  logic          busy, done, we_n;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_rdata = '0;
  logic [15:0]   sram_d1 = '0;

  sram_sample_unpacker_if smp ();
  assign smp.out_ready = rdy;

  sram_sample_unpacker dut (
    .Clock(clk), .Reset(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .SRAM_address(sram_addr), .SRAM_we_n(we_n),
    .SRAM_read_data(sram_rdata), .smp(smp)
  );

  always #5 clk = ~clk;

  // SRAM model: data for the address seen in cycle c is on the bus in cycle c+2.
  logic [15:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    sram_d1    <= mem[sram_addr];
    sram_rdata <= sram_d1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [15:0]   exp_q [$];
  logic [AW-1:0] addr_log [$];
  logic [AW-1:0] prev_addr = '0;
  int issued_n = 0, seen_n = 0, done_n = 0, done_cyc = 0, last_xfer_cyc = 0, cyc_no = 0;
  logic prev_stall = 1'b0;
  logic [15:0] prev_sample = '0;

  always @(posedge clk) cyc_no <= cyc_no + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (sram_addr != prev_addr && busy) begin
        issued_n++;
        addr_log.push_back(sram_addr);
        check("occupancy", 32'((issued_n - seen_n / 2) <= 4), 1);
      end
      if (prev_stall) begin
        check("stall_valid", 32'(smp.out_valid), 1);
        check("stall_sample", 32'(smp.out_sample), 32'(prev_sample));
      end
      if (smp.out_valid && rdy) begin
        seen_n++;
        last_xfer_cyc = cyc_no;
        check("sample_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("sample_value", 32'(smp.out_sample), 32'(exp_q.pop_front()));
      end
      prev_stall  = smp.out_valid && !rdy;
      prev_sample = smp.out_sample;
      if (done) begin
        done_n++;
        done_cyc = cyc_no;
        check("busy_low_at_done", 32'(busy), 0);
      end
    end else begin
      prev_stall = 1'b0;
    end
    prev_addr = sram_addr;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [15:0] n);
    base_addr  = b;
    word_count = n;
    start      = 1'b1;
    issued_n   = 0;
    seen_n     = 0;
    addr_log.delete();
    cyc();
    start = 1'b0;
  endtask

  task automatic finish_checks(input logic [AW-1:0] b, input int n, input int d0);
    int k;
    k = 0;
    while (done_n == d0 && k < 400) begin
      cyc();
      k++;
    end
    check("done_within_budget", 32'(done_n > d0), 1);
    check("done_after_last_xfer", 32'(done_cyc - last_xfer_cyc), 1);
    check("all_samples_delivered", 32'(exp_q.size()), 0);
    check("words_issued", 32'(addr_log.size()), 32'(n));
    for (int i = 0; i < addr_log.size(); i++)
      check("issue_address", 32'(addr_log[i]), 32'(AW'(b + AW'(i))));
    repeat (2) cyc();
    check("single_done", 32'(done_n - d0), 1);
  endtask

  task automatic run_xfer(input logic [AW-1:0] b, input int n);
    int d0, lat;
    d0 = done_n;
    pulse_start(b, 16'(n));
    check("busy_after_start", 32'(busy), 1);
    lat = 0;
    while (!smp.out_valid && lat < 50) begin
      cyc();
      lat++;
    end
    check("first_valid_latency", 32'(lat), 4);
    finish_checks(b, n, d0);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic [15:0]   exp_hi;
    logic [15:0]   exp_lo;
  } word_vec_t;

  typedef struct {
    logic [AW-1:0] base;
    int            count;
    int            first;
  } xfer_vec_t;

  word_vec_t wv [6];
  xfer_vec_t xv [3];

  initial begin
    int d0, k;
    logic bad;
    logic [AW-1:0] a0;

    wv[0] = '{18'h00100, 16'hFF00, 16'h007F, 16'hFF80};
    wv[1] = '{18'h00101, 16'h8001, 16'h0000, 16'hFF81};
    wv[2] = '{18'h00102, 16'h7F80, 16'hFFFF, 16'h0000};
    wv[3] = '{18'h00103, 16'h01FE, 16'hFF81, 16'h007E};
    wv[4] = '{18'h3FFFF, 16'h1234, 16'hFF92, 16'hFFB4};
    wv[5] = '{18'h00000, 16'hC0A5, 16'h0040, 16'h0025};
    xv[0] = '{18'h00100, 2, 0};
    xv[1] = '{18'h00102, 2, 2};
    xv[2] = '{18'h3FFFF, 2, 4};

    for (int i = 0; i < 6; i++) mem[wv[i].addr] = wv[i].data;
    for (int i = 0; i < 16; i++) mem[AW'(18'h200 + i)] = {8'(2 * i), 8'(2 * i + 1)};

    repeat (3) cyc();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_valid", 32'(smp.out_valid), 0);
    check("rst_sample", 32'(smp.out_sample), 0);
    check("rst_addr", 32'(sram_addr), 0);
    check("rst_we_n", 32'(we_n), 1);
    rst = 1'b0;
    cyc();

    // Table-driven transfers: order, level shift, address wrap.
    for (int t = 0; t < 3; t++) begin
      for (int w = 0; w < xv[t].count; w++) begin
        exp_q.push_back(wv[xv[t].first + w].exp_hi);
        exp_q.push_back(wv[xv[t].first + w].exp_lo);
      end
      run_xfer(xv[t].base, xv[t].count);
    end

    // Backpressure: 12 stalled cycles, then out_ready toggles.
    for (int j = 0; j < 32; j++) exp_q.push_back(16'(j) - 16'd128);
    d0  = done_n;
    rdy = 1'b0;
    pulse_start(18'h00200, 16'd16);
    repeat (12) cyc();
    check("bp_stalled_valid", 32'(smp.out_valid), 1);
    check("bp_stalled_head", 32'(smp.out_sample), 32'h0000FF80);
    k = 0;
    while (done_n == d0 && k < 400) begin
      rdy = ~rdy;
      cyc();
      k++;
    end
    rdy = 1'b1;
    finish_checks(18'h00200, 16, d0);

    // Zero-length transfer.
    d0 = done_n;
    a0 = sram_addr;
    pulse_start(18'h00155, 16'd0);
    check("zero_busy", 32'(busy), 1);
    check("zero_no_done_yet", 32'(done), 0);
    cyc();
    check("zero_done", 32'(done), 1);
    check("zero_busy_cleared", 32'(busy), 0);
    cyc();
    check("zero_done_ends", 32'(done), 0);
    check("zero_addr_unchanged", 32'(sram_addr), 32'(a0));
    check("zero_no_valid", 32'(smp.out_valid), 0);
    check("zero_single_done", 32'(done_n - d0), 1);

    // Start while busy is ignored.
    for (int w = 0; w < 4; w++) begin
      exp_q.push_back(wv[w].exp_hi);
      exp_q.push_back(wv[w].exp_lo);
    end
    d0 = done_n;
    pulse_start(18'h00100, 16'd4);
    repeat (3) cyc();
    base_addr  = 18'h3FFFF;
    word_count = 16'd2;
    start      = 1'b1;
    cyc();
    start = 1'b0;
    finish_checks(18'h00100, 4, d0);

    // Reset mid-transfer, then a normal transfer.
    for (int j = 0; j < 16; j++) exp_q.push_back(16'(j) - 16'd128);
    d0 = done_n;
    pulse_start(18'h00200, 16'd8);
    repeat (5) cyc();
    rst = 1'b1;
    cyc();
    exp_q.delete();
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_valid", 32'(smp.out_valid), 0);
    check("mid_rst_sample", 32'(smp.out_sample), 0);
    check("mid_rst_addr", 32'(sram_addr), 0);
    check("mid_rst_we_n", 32'(we_n), 1);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      bad = bad | smp.out_valid;
    end
    check("late_data_ignored", 32'(bad), 0);
    check("no_done_after_reset", 32'(done_n - d0), 0);
    for (int w = 0; w < 2; w++) begin
      exp_q.push_back(wv[w].exp_hi);
      exp_q.push_back(wv[w].exp_lo);
    end
    run_xfer(18'h00100, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
    $fatal(1);
  end

endmodule
